// File: rtl/rf_pkg.sv
// Shared defaults and address/word types for the multi-port register file.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width for a register count; never narrower than one bit.
    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int DEF_AW = addr_width(NREGS_DEF);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register, set by an
// accepted reservation and cleared by any enabled write to that register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = addr_width(NREGS),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_RD*AW-1:0] raddr_i,
    input  logic [NUM_WR-1:0]    we_i,
    input  logic [NUM_WR*AW-1:0] waddr_i,
    input  logic                 rsv_valid_i,
    input  logic [AW-1:0]        rsv_addr_i,
    output logic                 rsv_ready_o,
    output logic [NUM_RD-1:0]    rbusy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] clr;

    // One-hot-ish set of registers being written this cycle (x0 excluded).
    always_comb begin
        clr = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] && (waddr_i[k*AW +: AW] != '0))
                clr[waddr_i[k*AW +: AW]] = 1'b1;
        end
    end

    // A WAW stall only when the destination is busy and not being retired now.
    always_comb begin
        rsv_ready_o = !busy_q[rsv_addr_i] || clr[rsv_addr_i] || (rsv_addr_i == '0);
    end

    // Read-side hazard flag; a same-cycle forwarded write resolves it when bypassing.
    always_comb begin
        rbusy_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rbusy_o[r] = busy_q[raddr_i[r*AW +: AW]] &&
                         !((BYPASS != 0) && clr[raddr_i[r*AW +: AW]]);
        end
    end

    // Clear on write first, then set on reserve so a new producer wins the tie.
    always_comb begin
        busy_d = busy_q & ~clr;
        if (rsv_valid_i && rsv_ready_o && (rsv_addr_i != '0))
            busy_d[rsv_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy vector state; reset drops every outstanding reservation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

endmodule

// File: rtl/rf_riscv_mp.sv
// Multi-port integer register file: async reads with optional write bypass,
// sync writes with highest-port-wins merging, and a reservation scoreboard.
module rf_riscv_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1,
    parameter int AW     = addr_width(NREGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_RD*AW-1:0]   raddr_i,
    output logic [NUM_RD*XLEN-1:0] rdata_o,
    output logic [NUM_RD-1:0]      rbusy_o,
    input  logic [NUM_WR-1:0]      we_i,
    input  logic [NUM_WR*AW-1:0]   waddr_i,
    input  logic [NUM_WR*XLEN-1:0] wdata_i,
    input  logic                   rsv_valid_i,
    input  logic [AW-1:0]          rsv_addr_i,
    output logic                   rsv_ready_o
);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0][XLEN-1:0] regs_d;

    // Apply write ports in ascending order so the highest index wins a collision.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] && (waddr_i[k*AW +: AW] != '0))
                regs_d[waddr_i[k*AW +: AW]] = wdata_i[k*XLEN +: XLEN];
        end
        regs_d[0] = '0;
    end

    // Storage array; x0 is held at zero by the merge above.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) regs_q <= '0;
        else         regs_q <= regs_d;
    end

    // Per-port read mux with forwarding; output forced to zero while reset is held
    // so a forwarded write cannot leak through during reset.
    always_comb begin
        rdata_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] val;
            ra  = raddr_i[r*AW +: AW];
            val = regs_q[ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (we_i[k] && (waddr_i[k*AW +: AW] == ra))
                        val = wdata_i[k*XLEN +: XLEN];
                end
            end
            if ((ra == '0) || !rst_ni)
                val = '0;
            rdata_o[r*XLEN +: XLEN] = val;
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .raddr_i     (raddr_i),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .rsv_valid_i (rsv_valid_i),
        .rsv_addr_i  (rsv_addr_i),
        .rsv_ready_o (rsv_ready_o),
        .rbusy_o     (rbusy_o)
    );

endmodule

// File: tb/tb_rf_riscv_mp.sv
// Scoreboard bench: two register files (bypass on / off, two write ports) share
// stimulus; a reference model queues expected outputs, a monitor compares them.
module tb_rf_riscv_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  raddr = '0;
    logic [1:0]  we = '0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic        rsv_v = 1'b0;
    logic [4:0]  rsv_a = '0;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic        ready_a, ready_b;

    always #5 clk = ~clk;

    rf_riscv_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .rsv_valid_i(rsv_v), .rsv_addr_i(rsv_a), .rsv_ready_o(ready_a));

    rf_riscv_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .rsv_valid_i(rsv_v), .rsv_addr_i(rsv_a), .rsv_ready_o(ready_b));

    typedef struct {
        logic [31:0] rd_a [2];
        logic [31:0] rd_b [2];
        logic        rb_a [2];
        logic        rb_b [2];
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: architectural register values and pending-producer flags.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue what the DUTs must show, advance the model.
    task automatic step(input logic [1:0] w_en, input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic rv, input logic [4:0] ra, input logic rst);
        exp_t        e;
        logic [4:0]  rds [2];
        logic [4:0]  wad [2];
        logic [31:0] wdv [2];
        bit          hit;
        @(posedge clk);
        #1;
        rst_n = !rst;
        we    = w_en;
        waddr = {5'd0, wa1, wa0};
        wdata = {wd1, wd0};
        raddr = {ra1, ra0};
        rsv_v = rv;
        rsv_a = ra;
        rds[0] = ra0; rds[1] = ra1;
        wad[0] = wa0; wad[1] = wa1;
        wdv[0] = wd0; wdv[1] = wd1;
        for (int r = 0; r < 2; r++) begin
            logic [31:0] fwd;
            hit = 0;
            fwd = 0;
            for (int k = 0; k < 2; k++)
                if (w_en[k] && wad[k] == rds[r] && rds[r] != 0) begin hit = 1; fwd = wdv[k]; end
            if (rst || rds[r] == 0) begin
                e.rd_a[r] = 0; e.rd_b[r] = 0; e.rb_a[r] = 0; e.rb_b[r] = 0;
            end else begin
                e.rd_b[r] = m_regs[rds[r]];
                e.rd_a[r] = hit ? fwd : m_regs[rds[r]];
                e.rb_b[r] = m_busy[rds[r]];
                e.rb_a[r] = m_busy[rds[r]] && !hit;
            end
        end
        hit = 0;
        for (int k = 0; k < 2; k++)
            if (w_en[k] && wad[k] == ra && ra != 0) hit = 1;
        e.ready = rst || ra == 0 || !m_busy[ra] || hit;
        exp_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
        end else begin
            for (int k = 0; k < 2; k++)
                if (w_en[k] && wad[k] != 0) begin m_regs[wad[k]] = wdv[k]; m_busy[wad[k]] = 0; end
            if (rv && e.ready && ra != 0) m_busy[ra] = 1;
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("rdata_byp[%0d]", r), rdata_a[r*32 +: 32], e.rd_a[r]);
                chk($sformatf("rdata_nobyp[%0d]", r), rdata_b[r*32 +: 32], e.rd_b[r]);
                chk($sformatf("rbusy_byp[%0d]", r), {31'd0, rbusy_a[r]}, {31'd0, e.rb_a[r]});
                chk($sformatf("rbusy_nobyp[%0d]", r), {31'd0, rbusy_b[r]}, {31'd0, e.rb_b[r]});
            end
            chk("rsv_ready_byp", {31'd0, ready_a}, {31'd0, e.ready});
            chk("rsv_ready_nobyp", {31'd0, ready_b}, {31'd0, e.ready});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
        // Reset held, even with a write and reserve presented.
        step(2'b01, 5'd5, 5'd0, 32'h1111_1111, 0, 5'd5, 5'd0, 1, 5'd5, 1);
        step(2'b00, 0, 0, 0, 0, 5'd5, 5'd0, 0, 5'd0, 1);
        // Write x5, see it, then reset mid-operation (with a reservation pending).
        step(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 0, 5'd5, 5'd0, 1, 5'd5, 0);
        step(2'b00, 0, 0, 0, 0, 5'd5, 5'd0, 0, 5'd5, 0);
        step(2'b00, 0, 0, 0, 0, 5'd5, 5'd0, 0, 5'd5, 1);
        step(2'b00, 0, 0, 0, 0, 5'd5, 5'd0, 0, 5'd5, 0);
        // x0 hardwired; reserving x0 is accepted but never marks busy.
        step(2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0, 1, 5'd0, 0);
        step(2'b00, 0, 0, 0, 0, 5'd0, 5'd0, 1, 5'd0, 0);
        // Bypass: same-cycle forward vs array value, then visible next cycle.
        step(2'b01, 5'd3, 5'd0, 32'h0000_1234, 0, 5'd3, 5'd3, 0, 5'd0, 0);
        step(2'b00, 0, 0, 0, 0, 5'd3, 5'd0, 0, 5'd0, 0);
        // Collision: port 1 wins.
        step(2'b11, 5'd7, 5'd7, 32'h0000_AAAA, 32'h0000_BBBB, 5'd7, 5'd0, 0, 5'd0, 0);
        step(2'b00, 0, 0, 0, 0, 5'd7, 5'd3, 0, 5'd0, 0);
        // Scoreboard: reserve, WAW stall, clear by write, write+reserve same edge.
        step(2'b00, 0, 0, 0, 0, 5'd9, 5'd0, 1, 5'd9, 0);
        step(2'b00, 0, 0, 0, 0, 5'd9, 5'd0, 1, 5'd9, 0);
        step(2'b01, 5'd9, 5'd0, 32'h9999, 0, 5'd9, 5'd0, 0, 5'd9, 0);
        step(2'b00, 0, 0, 0, 0, 5'd9, 5'd0, 1, 5'd9, 0);
        step(2'b10, 5'd0, 5'd9, 0, 32'h5A5A, 5'd9, 5'd9, 1, 5'd9, 0);
        step(2'b00, 0, 0, 0, 0, 5'd9, 5'd0, 0, 5'd9, 0);
        // Randomized traffic on a small address window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] hold_a;
            hold_a = 5'($urandom_range(0, 7));
            step(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom), hold_a, ($urandom_range(0, 63) == 0));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
